// File: rtl/xosera_pkg.sv
// Shared copper types and constants for the fetch unit and copper program memories.
package xosera_pkg;

  localparam int unsigned COPP_AWIDTH = 10;

  typedef struct packed {
    logic [15:0] even;
    logic [15:0] odd;
  } copp_instr_t;

endpackage

// File: rtl/copper_fetch_fifo.sv
// Two-entry prefetch FIFO of {instruction, address}; head is presented directly from storage.
module copper_fetch_fifo
  import xosera_pkg::*;
#(
  parameter int unsigned AWIDTH = COPP_AWIDTH
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  copp_instr_t       i_instr,
  input  logic [AWIDTH-1:0] i_addr,
  output copp_instr_t       o_instr,
  output logic [AWIDTH-1:0] o_addr,
  output logic [1:0]        o_count,
  output logic              o_valid
);

  copp_instr_t       r_instr [2];
  logic [AWIDTH-1:0] r_addr  [2];
  logic [1:0]        r_count;
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic              w_pop;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign o_instr = r_instr[r_rd_ptr];
  assign o_addr  = r_addr[r_rd_ptr];
  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_instr[i] <= '0;
        r_addr[i]  <= '0;
      end
    end else if (i_flush) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (i_push) begin
        r_instr[r_wr_ptr] <= i_instr;
        r_addr[r_wr_ptr]  <= i_addr;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
    end
  end

  // The issue throttle upstream must make a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (reset_n_i && !i_flush) begin
      assert (!(i_push && !w_pop && (r_count == 2'd2)));
    end
  end

endmodule

// File: rtl/copper_fetch.sv
// Copper instruction fetch: pc, one in-flight memory read, redirect handling and prefetch FIFO.
module copper_fetch
  import xosera_pkg::*;
#(
  parameter int unsigned AWIDTH = COPP_AWIDTH
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              en_i,
  input  logic              restart_i,
  input  logic              branch_i,
  input  logic [AWIDTH-1:0] branch_addr_i,
  output logic [AWIDTH-1:0] mem_addr_o,
  input  logic [15:0]       mem_even_data_i,
  input  logic [15:0]       mem_odd_data_i,
  output logic [31:0]       instr_o,
  output logic [AWIDTH-1:0] instr_addr_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i
);

  logic [AWIDTH-1:0] r_pc;
  logic              r_inflight;
  logic [AWIDTH-1:0] r_inflight_addr;

  logic [AWIDTH-1:0] w_pc_next;
  logic [AWIDTH-1:0] w_target;
  logic [1:0]        w_count;
  logic [2:0]        w_level;
  logic              w_pop;
  logic              w_push;
  logic              w_redirect;
  logic              w_issue;
  copp_instr_t       w_mem_instr;
  copp_instr_t       w_head;

  assign w_pop       = instr_valid_o && instr_ready_i;
  assign w_redirect  = branch_i || restart_i;
  // Restart outranks branch when both pulse together.
  assign w_target    = restart_i ? '0 : branch_addr_i;
  assign w_level     = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue     = en_i && !w_redirect && (w_level < 3'd2);
  assign w_push      = r_inflight && !w_redirect;
  assign w_mem_instr = '{even: mem_even_data_i, odd: mem_odd_data_i};

  assign mem_addr_o  = r_pc;
  assign instr_o     = w_head;

  always_comb begin
    w_pc_next = r_pc;
    if (w_redirect) begin
      w_pc_next = w_target;
    end else if (w_issue) begin
      w_pc_next = r_pc + AWIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_pc            <= '0;
      r_inflight      <= 1'b0;
      r_inflight_addr <= '0;
    end else begin
      r_pc       <= w_pc_next;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_addr <= r_pc;
      end
    end
  end

  copper_fetch_fifo #(
    .AWIDTH(AWIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n_i(reset_n_i),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_flush  (w_redirect),
    .i_instr  (w_mem_instr),
    .i_addr   (r_inflight_addr),
    .o_instr  (w_head),
    .o_addr   (instr_addr_o),
    .o_count  (w_count),
    .o_valid  (instr_valid_o)
  );

endmodule
